// File: rtl/bsg_front_side_bus_hop_in_mcast_pkg.sv
// rtl/bsg_front_side_bus_hop_in_mcast_pkg.sv - shared defaults and pointer helper for the multicast FSB hop
package bsg_front_side_bus_hop_in_mcast_pkg;

  localparam int unsigned width_default_lp   = 16;
  localparam int unsigned fan_out_default_lp = 5;
  localparam int unsigned els_default_lp     = 2;

  // Circular pointer increment for a depth that need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned els);
    return (ptr + 1 == els) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small flop FIFO, ready-then-valid input, valid-yumi output
module bsg_fifo_1r1w_small
  import bsg_front_side_bus_hop_in_mcast_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic                last_enq_q, last_enq_d;
  logic                ptr_eq, full, empty, enq, deq;

  // Equal pointers are ambiguous; the last operation tells full from empty.
  assign ptr_eq  = (rd_ptr_q == wr_ptr_q);
  assign full    = ptr_eq & last_enq_q;
  assign empty   = ptr_eq & ~last_enq_q;
  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign enq     = v_i & ~full;
  assign deq     = yumi_i & ~empty;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    last_enq_d = last_enq_q;
    if (enq) begin
      wr_ptr_d = ptr_w_lp'(wrap_inc(int'(wr_ptr_q), els_p));
    end
    if (deq) begin
      rd_ptr_d = ptr_w_lp'(wrap_inc(int'(rd_ptr_q), els_p));
    end
    if (enq & ~deq) begin
      last_enq_d = 1'b1;
    end else if (deq & ~enq) begin
      last_enq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      last_enq_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      last_enq_q <= last_enq_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/bsg_front_side_bus_hop_in_mcast.sv
// rtl/bsg_front_side_bus_hop_in_mcast.sv - buffered FSB fan-out hop with per-packet destination mask
module bsg_front_side_bus_hop_in_mcast
  import bsg_front_side_bus_hop_in_mcast_pkg::*;
#(
  parameter int width_p   = width_default_lp,
  parameter int fan_out_p = fan_out_default_lp,
  parameter int els_p     = els_default_lp
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
  input  logic [fan_out_p-1:0]         mask_i,
  output logic                         ready_o,
  output logic [fan_out_p-1:0]         v_o,
  output logic [fan_out_p*width_p-1:0] data_o,
  input  logic [fan_out_p-1:0]         ready_i
);

  localparam int fifo_width_lp = width_p + fan_out_p;

  logic                     fifo_ready, head_v, head_live, done;
  logic [fifo_width_lp-1:0] head;
  logic [fan_out_p-1:0]     head_mask;
  logic [width_p-1:0]       head_data;
  logic [fan_out_p-1:0]     sent_q, sent_d, sent_n;

  bsg_fifo_1r1w_small #(
    .width_p (fifo_width_lp),
    .els_p   (els_p)
  ) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i & ~reset_i),
    .ready_o (fifo_ready),
    .data_i  ({mask_i, data_i}),
    .v_o     (head_v),
    .data_o  (head),
    .yumi_i  (done)
  );

  assign ready_o   = fifo_ready & ~reset_i;
  assign head_live = head_v & ~reset_i;
  assign head_mask = head[width_p +: fan_out_p];
  assign head_data = head[width_p-1:0];

  // A channel that already took the head stays quiet until the packet retires.
  assign v_o    = {fan_out_p{head_live}} & head_mask & ~sent_q;
  assign sent_n = sent_q | (v_o & ready_i);
  assign done   = head_live & (&(sent_n | ~head_mask));
  assign sent_d = done ? '0 : sent_n;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sent_q <= '0;
    end else begin
      sent_q <= sent_d;
    end
  end

  for (genvar i = 0; i < fan_out_p; i++) begin : g_out
    assign data_o[i*width_p +: width_p] = head_data;
  end

endmodule

// File: tb/tb_bsg_front_side_bus_hop_in_mcast.sv
// tb/tb_bsg_front_side_bus_hop_in_mcast.sv - scoreboard bench for the multicast FSB hop
module tb_bsg_front_side_bus_hop_in_mcast;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic [15:0] data_i;
  logic [4:0]  mask_i;
  logic        ready_o;
  logic [4:0]  v_o;
  logic [79:0] data_o;
  logic [4:0]  ready_i;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] exp_q [5][$];

  bsg_front_side_bus_hop_in_mcast #(
    .width_p   (16),
    .fan_out_p (5),
    .els_p     (2)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .mask_i  (mask_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: per-channel expected packets, pushed on enqueue, popped on transfer.
  always @(negedge clk) begin
    if (reset_i) begin
      for (int i = 0; i < 5; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (v_o[i] && ready_i[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("ch%0d_unexpected", i), 80'(v_o[i]), 80'd0);
          end else begin
            check($sformatf("ch%0d_data", i), 80'(data_o[i*16 +: 16]), 80'(exp_q[i].pop_front()));
          end
        end
      end
      if (v_i && ready_o) begin
        for (int i = 0; i < 5; i++) begin
          if (mask_i[i]) exp_q[i].push_back(data_i);
        end
      end
    end
  end

  initial begin
    reset_i = 1'b1;
    v_i     = 1'b0;
    data_i  = '0;
    mask_i  = '0;
    ready_i = '0;
    smp();
    check("reset_ready", 80'(ready_o), 80'd0);
    check("reset_v", 80'(v_o), 80'd0);
    cyc();
    reset_i = 1'b0;
    smp();
    check("post_reset_ready", 80'(ready_o), 80'd1);
    check("post_reset_v", 80'(v_o), 80'd0);

    // Broadcast with every channel ready
    cyc();
    v_i = 1'b1; data_i = 16'hA5A5; mask_i = 5'b11111; ready_i = 5'b11111;
    smp();
    check("bc_ready", 80'(ready_o), 80'd1);
    cyc();
    v_i = 1'b0;
    smp();
    check("bc_v", 80'(v_o), 80'(5'b11111));
    check("bc_data", data_o, {5{16'hA5A5}});
    cyc();
    smp();
    check("bc_retired", 80'(v_o), 80'd0);

    // Staggered acceptance
    cyc();
    v_i = 1'b1; data_i = 16'h1234; mask_i = 5'b10101; ready_i = 5'b00000;
    cyc();
    v_i = 1'b0; ready_i = 5'b00001;
    smp();
    check("stag_v0", 80'(v_o), 80'(5'b10101));
    cyc();
    ready_i = 5'b10000;
    smp();
    check("stag_v1", 80'(v_o), 80'(5'b10100));
    cyc();
    ready_i = 5'b00100;
    smp();
    check("stag_v2", 80'(v_o), 80'(5'b00100));
    cyc();
    ready_i = 5'b00000;
    smp();
    check("stag_done", 80'(v_o), 80'd0);

    // Zero-mask packet is dropped silently
    cyc();
    v_i = 1'b1; data_i = 16'h1111; mask_i = 5'b00000; ready_i = 5'b11111;
    cyc();
    data_i = 16'h2222; mask_i = 5'b00010;
    smp();
    check("zm_first_v", 80'(v_o), 80'd0);
    cyc();
    v_i = 1'b0;
    smp();
    check("zm_second_v", 80'(v_o), 80'(5'b00010));
    check("zm_second_data", 80'(data_o[16 +: 16]), 80'(16'h2222));
    cyc();
    smp();
    check("zm_done", 80'(v_o), 80'd0);

    // Backpressure: third packet waits for a free slot
    cyc();
    v_i = 1'b1; data_i = 16'h0001; mask_i = 5'b11111; ready_i = 5'b00000;
    smp();
    check("bp_ready0", 80'(ready_o), 80'd1);
    cyc();
    data_i = 16'h0002;
    smp();
    check("bp_ready1", 80'(ready_o), 80'd1);
    cyc();
    data_i = 16'h0003;
    smp();
    check("bp_full", 80'(ready_o), 80'd0);
    check("bp_head1", 80'(data_o[15:0]), 80'(16'h0001));
    cyc();
    ready_i = 5'b11111;
    smp();
    check("bp_no_bypass", 80'(ready_o), 80'd0);
    check("bp_v_held", 80'(v_o), 80'(5'b11111));
    cyc();
    smp();
    check("bp_ready_again", 80'(ready_o), 80'd1);
    check("bp_head2", 80'(data_o[15:0]), 80'(16'h0002));
    cyc();
    v_i = 1'b0;
    smp();
    check("bp_head3", 80'(data_o[15:0]), 80'(16'h0003));
    cyc();
    smp();
    check("bp_empty", 80'(v_o), 80'd0);

    // Reset in the middle of a partial delivery
    cyc();
    v_i = 1'b1; data_i = 16'h5555; mask_i = 5'b11111; ready_i = 5'b00001;
    cyc();
    v_i = 1'b0;
    smp();
    check("rst_mid_v", 80'(v_o), 80'(5'b11111));
    cyc();
    reset_i = 1'b1;
    smp();
    check("rst_mid_v_in_reset", 80'(v_o), 80'd0);
    check("rst_mid_ready_in_reset", 80'(ready_o), 80'd0);
    cyc();
    reset_i = 1'b0; ready_i = 5'b11111;
    smp();
    check("rst_after_v", 80'(v_o), 80'd0);
    check("rst_after_ready", 80'(ready_o), 80'd1);
    cyc();
    smp();
    check("rst_no_stale", 80'(v_o), 80'd0);

    // Random traffic checked by the scoreboard
    for (int n = 0; n < 10000; n++) begin
      cyc();
      v_i     = 1'($urandom_range(0, 1));
      data_i  = 16'($urandom);
      mask_i  = ($urandom_range(0, 7) == 0) ? 5'b00000 : 5'($urandom);
      ready_i = 5'($urandom);
    end
    cyc();
    v_i = 1'b0; ready_i = 5'b11111;
    repeat (20) cyc();
    smp();
    check("drain_v", 80'(v_o), 80'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain_ch%0d_left", i), 80'(exp_q[i].size()), 80'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
